// File: rtl/vec_seq_pkg.sv
// Shared types and constants for the vector memory sequencer.
package vec_seq_pkg;
  typedef enum logic [2:0] {IDLE, STORE, LOAD, DRAIN, COMMIT} state_e;
  localparam int BEATS  = 8;
  localparam int LANE_W = $clog2(BEATS);
endpackage

// File: rtl/vector_mem_sequencer_if.sv
// Request, scalar memory and vector register file signals of the sequencer.
interface vector_mem_sequencer_if #(parameter int N = 32, parameter int V = 256, parameter int R = 5);
  logic         start;
  logic         is_store;
  logic [N-1:0] base_addr;
  logic [R-1:0] wa3;
  logic [V-1:0] store_data;
  logic         stall;
  logic         done;
  logic [N-1:0] mem_addr;
  logic         mem_we;
  logic [N-1:0] mem_wd;
  logic [N-1:0] mem_rd;
  logic         vwe;
  logic [R-1:0] vwa;
  logic [V-1:0] vwd;

  modport master (output start, is_store, base_addr, wa3, store_data, mem_rd,
                  input  stall, done, mem_addr, mem_we, mem_wd, vwe, vwa, vwd);
  modport slave  (input  start, is_store, base_addr, wa3, store_data, mem_rd,
                  output stall, done, mem_addr, mem_we, mem_wd, vwe, vwa, vwd);
endinterface

// File: rtl/vector_lane_buffer.sv
// Vector assembly register: one N-bit lane per beat, per-lane write enable, sync clear.
module vector_lane_buffer import vec_seq_pkg::*; #(
  parameter int N = 32,
  parameter int V = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [BEATS-1:0] we,
  input  logic [N-1:0]     wd,
  output logic [V-1:0]     q
);
  logic [BEATS-1:0][N-1:0] lane_q, lane_d;

  always_comb begin
    lane_d = lane_q;
    for (int i = 0; i < BEATS; i++) begin
      if (clr)        lane_d[i] = '0;
      else if (we[i]) lane_d[i] = wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lane_q <= '0;
    else     lane_q <= lane_d;
  end

  assign q = lane_q;
endmodule

// File: rtl/vector_mem_sequencer.sv
// Splits one vector load/store into BEATS word accesses on a scalar memory port.
module vector_mem_sequencer import vec_seq_pkg::*; #(
  parameter int N = 32,
  parameter int V = 256,
  parameter int R = 5
) (
  input logic                   clk,
  input logic                   rst,
  vector_mem_sequencer_if.slave bus
);
  state_e              state_q, state_d;
  logic [LANE_W-1:0]   cnt_q, cnt_d;
  logic                is_store_q, is_store_d;
  logic [N-1:0]        base_q, base_d;
  logic [R-1:0]        wa3_q, wa3_d;
  logic [V-1:0]        sd_q, sd_d;
  logic                accept;
  logic [BEATS-1:0]    lane_we;
  logic [V-1:0]        lanes;

  assign accept = (state_q == IDLE) && bus.start;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    base_d     = base_q;
    wa3_d      = wa3_q;
    sd_d       = sd_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d    = bus.is_store ? STORE : LOAD;
        cnt_d      = '0;
        is_store_d = bus.is_store;
        base_d     = {bus.base_addr[N-1:2], 2'b00};
        wa3_d      = bus.wa3;
        sd_d       = bus.store_data;
      end
      STORE: begin
        cnt_d = cnt_q + LANE_W'(1);
        if (cnt_q == LANE_W'(BEATS-1)) state_d = COMMIT;
      end
      LOAD: begin
        cnt_d = cnt_q + LANE_W'(1);
        if (cnt_q == LANE_W'(BEATS-1)) state_d = DRAIN;
      end
      DRAIN:   state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      base_q     <= '0;
      wa3_q      <= '0;
      sd_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      base_q     <= base_d;
      wa3_q      <= wa3_d;
      sd_q       <= sd_d;
    end
  end

  // Read data trails its address by one cycle, so beat cnt-1 lands while cnt is issued.
  always_comb begin
    lane_we = '0;
    if (state_q == LOAD && cnt_q != '0) lane_we[cnt_q - LANE_W'(1)] = 1'b1;
    else if (state_q == DRAIN)          lane_we[BEATS-1] = 1'b1;
  end

  vector_lane_buffer #(.N(N), .V(V)) u_buf (
    .clk(clk), .rst(rst), .clr(accept), .we(lane_we), .wd(bus.mem_rd), .q(lanes)
  );

  assign bus.stall    = (state_q inside {STORE, LOAD, DRAIN}) || (accept && !rst);
  assign bus.mem_we   = (state_q == STORE);
  assign bus.mem_addr = (state_q inside {STORE, LOAD}) ? base_q + N'({cnt_q, 2'b00}) : '0;
  assign bus.mem_wd   = (state_q == STORE) ? sd_q[int'(cnt_q)*N +: N] : '0;
  assign bus.done     = (state_q == COMMIT);
  assign bus.vwe      = (state_q == COMMIT) && !is_store_q;
  assign bus.vwa      = bus.vwe ? wa3_q : '0;
  assign bus.vwd      = bus.vwe ? lanes : '0;
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench: cycle timeline model of each request plus literal checks on logged traffic.
module tb_vector_mem_sequencer;
  localparam int N = 32, V = 256, R = 5, MAXC = 1024;

  logic clk, rst;
  vector_mem_sequencer_if #(.N(N), .V(V), .R(R)) bus ();
  vector_mem_sequencer #(.N(N), .V(V), .R(R)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Word memory: untouched words read a fixed pattern, 0x200+4i -> 0xA0000000+i.
  logic [31:0] wr_mem [0:1023];
  bit          wr_v   [0:1023];
  function automatic logic [31:0] rdw(input logic [31:0] a);
    logic [31:0] w;
    w = 32'hA0000000 + ((a - 32'h200) >> 2);
    if (wr_v[a[11:2]]) w = wr_mem[a[11:2]];
    return w;
  endfunction
  always @(posedge clk) begin
    bus.mem_rd <= rdw(bus.mem_addr);
    if (bus.mem_we) begin
      wr_mem[bus.mem_addr[11:2]] <= bus.mem_wd;
      wr_v[bus.mem_addr[11:2]]   <= 1'b1;
    end
  end

  // Expected outputs per cycle, filled in when the model accepts a request.
  bit         e_busy[MAXC], e_we[MAXC], e_done[MAXC], e_vwe[MAXC];
  bit [31:0]  e_addr[MAXC], e_wd[MAXC];
  bit [4:0]   e_vwa[MAXC];
  bit [255:0] e_vwd[MAXC];
  int idle_from = 0;

  typedef struct {int c; logic [31:0] a; logic [31:0] d;} wr_t;
  typedef struct {int c; logic [4:0] wa; logic [255:0] d;} vw_t;
  wr_t wr_log[$];
  vw_t vw_log[$];
  int  done_log[$];

  always @(negedge clk) begin
    logic [31:0] base;
    logic [255:0] v;
    bit idle_now, exp_stall;
    if (cyc + 12 < MAXC) begin
      if (rst) begin
        for (int k = cyc; k < MAXC; k++) begin
          e_busy[k] = 0; e_we[k] = 0; e_done[k] = 0; e_vwe[k] = 0;
          e_addr[k] = 0; e_wd[k] = 0; e_vwa[k] = 0; e_vwd[k] = 0;
        end
        idle_from = cyc;
      end
      idle_now  = !rst && cyc >= idle_from;
      exp_stall = e_busy[cyc] || (idle_now && bus.start);
      n_tests++;
      if ({bus.stall, bus.mem_we, bus.mem_addr, bus.mem_wd, bus.done, bus.vwe, bus.vwa, bus.vwd} !==
          {exp_stall, e_we[cyc], e_addr[cyc], e_wd[cyc], e_done[cyc], e_vwe[cyc], e_vwa[cyc], e_vwd[cyc]}) begin
        n_fail++;
        $display("FAIL cycle_%0d outputs: got stall=%b we=%b addr=%h wd=%h done=%b vwe=%b vwa=%0d vwd=%h | want stall=%b we=%b addr=%h wd=%h done=%b vwe=%b vwa=%0d vwd=%h",
                 cyc, bus.stall, bus.mem_we, bus.mem_addr, bus.mem_wd, bus.done, bus.vwe, bus.vwa, bus.vwd,
                 exp_stall, e_we[cyc], e_addr[cyc], e_wd[cyc], e_done[cyc], e_vwe[cyc], e_vwa[cyc], e_vwd[cyc]);
      end
      if (bus.mem_we) wr_log.push_back('{cyc, bus.mem_addr, bus.mem_wd});
      if (bus.vwe)    vw_log.push_back('{cyc, bus.vwa, bus.vwd});
      if (bus.done)   done_log.push_back(cyc);
      if (idle_now && bus.start) begin
        base = {bus.base_addr[31:2], 2'b00};
        for (int i = 0; i < 8; i++) begin
          e_busy[cyc+1+i] = 1;
          e_addr[cyc+1+i] = base + 32'(4*i);
          if (bus.is_store) begin
            e_we[cyc+1+i] = 1;
            e_wd[cyc+1+i] = bus.store_data[32*i +: 32];
          end
          v[32*i +: 32] = rdw(base + 32'(4*i));
        end
        if (bus.is_store) begin
          e_done[cyc+9] = 1;
          idle_from = cyc + 10;
        end else begin
          e_busy[cyc+9]  = 1;
          e_done[cyc+10] = 1;
          e_vwe[cyc+10]  = 1;
          e_vwa[cyc+10]  = bus.wa3;
          e_vwd[cyc+10]  = v;
          idle_from = cyc + 11;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete(); vw_log.delete(); done_log.delete();
  endtask

  // One-cycle start pulse, then scramble the request inputs to prove they were captured.
  task automatic req(input logic st, input logic [31:0] ba, input logic [4:0] w,
                     input logic [255:0] sd, output int t);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.is_store = st; bus.base_addr = ba; bus.wa3 = w; bus.store_data = sd;
    t = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.is_store = ~st; bus.base_addr = $urandom; bus.wa3 = 5'($urandom);
    for (int i = 0; i < 8; i++) bus.store_data[32*i +: 32] = $urandom;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_log.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("done_wait", done_log.size(), n);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [255:0] sd;
    rst = 1'b1;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.base_addr = '0; bus.wa3 = '0; bus.store_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_we", bus.mem_we, 0);
    chk("reset_stall", bus.stall, 0);
    chk("reset_vwd", bus.vwd, 0);
    rst = 1'b0;

    // Store at 0x100, lanes 0x11111111*(i+1)
    for (int i = 0; i < 8; i++) sd[32*i +: 32] = 32'h11111111 * (i + 1);
    clear_logs();
    req(1'b1, 32'h100, 5'd0, sd, t);
    wait_done(1, 20);
    chk("st_n_writes", wr_log.size(), 8);
    if (wr_log.size() == 8) begin
      chk("st_w0_addr", wr_log[0].a, 32'h100);
      chk("st_w0_data", wr_log[0].d, 32'h11111111);
      chk("st_w0_cycle", wr_log[0].c, t + 1);
      chk("st_w7_addr", wr_log[7].a, 32'h11C);
      chk("st_w7_data", wr_log[7].d, 32'h88888888);
      chk("st_w7_cycle", wr_log[7].c, t + 8);
    end
    if (done_log.size() > 0) chk("st_done_cycle", done_log[0], t + 9);

    // Load at 0x200 into v7
    clear_logs();
    req(1'b0, 32'h200, 5'd7, '0, t);
    wait_done(1, 20);
    chk("ld_n_vwe", vw_log.size(), 1);
    if (vw_log.size() == 1) begin
      chk("ld_vwe_cycle", vw_log[0].c, t + 10);
      chk("ld_vwa", vw_log[0].wa, 7);
      chk("ld_lane0", vw_log[0].d[31:0], 32'hA0000000);
      chk("ld_lane3", vw_log[0].d[127:96], 32'hA0000003);
      chk("ld_lane7", vw_log[0].d[255:224], 32'hA0000007);
    end

    // Address wrap past the top of memory
    for (int i = 0; i < 8; i++) sd[32*i +: 32] = $urandom;
    clear_logs();
    req(1'b1, 32'hFFFFFFF8, 5'd0, sd, t);
    wait_done(1, 20);
    if (wr_log.size() == 8) begin
      chk("wrap_a1", wr_log[1].a, 32'hFFFFFFFC);
      chk("wrap_a2", wr_log[2].a, 32'h0);
      chk("wrap_a7", wr_log[7].a, 32'h14);
      chk("wrap_d2", wr_log[2].d, sd[95:64]);
    end else chk("wrap_n_writes", wr_log.size(), 8);

    // Unaligned base is word-aligned
    clear_logs();
    req(1'b1, 32'h103, 5'd0, sd, t);
    wait_done(1, 20);
    if (wr_log.size() == 8) begin
      chk("unal_a0", wr_log[0].a, 32'h100);
      chk("unal_a3", wr_log[3].a, 32'h10C);
    end else chk("unal_n_writes", wr_log.size(), 8);

    // Reset during load beat 4, then a clean load
    clear_logs();
    req(1'b0, 32'h200, 5'd5, '0, t);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_addr", bus.mem_addr, 0);
    chk("rst_async_stall", bus.stall, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (14) @(posedge clk);
    chk("rst_no_vwe", vw_log.size(), 0);
    chk("rst_no_done", done_log.size(), 0);
    clear_logs();
    req(1'b0, 32'h200, 5'd3, '0, t);
    wait_done(1, 20);
    if (vw_log.size() == 1) begin
      chk("post_rst_vwa", vw_log[0].wa, 3);
      chk("post_rst_lane7", vw_log[0].d[255:224], 32'hA0000007);
      chk("post_rst_cycle", vw_log[0].c, t + 10);
    end else chk("post_rst_n_vwe", vw_log.size(), 1);

    // start held high through COMMIT
    for (int i = 0; i < 8; i++) sd[32*i +: 32] = 32'hC0DE0000 + 32'(i);
    clear_logs();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.is_store = 1'b1; bus.base_addr = 32'h300; bus.store_data = sd;
    t = cyc;
    repeat (11) begin @(posedge clk); #1; end
    bus.start = 1'b0;
    wait_done(2, 30);
    if (done_log.size() == 2) begin
      chk("b2b_done0", done_log[0], t + 9);
      chk("b2b_done1", done_log[1], t + 19);
    end
    chk("b2b_n_writes", wr_log.size(), 16);
    if (wr_log.size() == 16) chk("b2b_second_first_beat", wr_log[8].c, t + 11);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vector_mem_sequencer.md
VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

Interface
REQ-001 Parameter N, default 32: scalar word and memory data width.
REQ-002 Parameter V, default 256: vector register width; BEATS = V/N = 8.
REQ-003 Parameter R, default 5: register address width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  vector memory request; sampled only in IDLE.
REQ-007 is_store  in  1  1 = vector store, 0 = vector load; sampled with start.
REQ-008 base_addr  in  N  byte address of lane 0; sampled with start.
REQ-009 wa3  in  R  destination vector register for loads; sampled with start.
REQ-010 store_data  in  V  vector to store; sampled with start.
REQ-011 mem_addr  out  N  word-aligned memory address.
REQ-012 mem_we  out  1  memory write enable.
REQ-013 mem_wd  out  N  memory write data.
REQ-014 mem_rd  in  N  memory read data; synchronous read, valid one cycle after mem_addr.
REQ-015 stall  out  1  freeze the pipeline stages upstream of the sequencer.
REQ-016 vwe  out  1  vector register file write enable.
REQ-017 vwa  out  R  vector register file write address.
REQ-018 vwd  out  V  vector register file write data.
REQ-019 done  out  1  one-cycle completion pulse.

Function
REQ-020 States: IDLE, STORE, LOAD, DRAIN, COMMIT; 3-bit beat counter cnt.
REQ-021 IDLE: start=1 captures is_store, base_addr with bits [1:0] forced to 0, wa3, store_data; cnt <= 0; next state STORE if is_store, else LOAD.
REQ-022 stall = 1 in STORE, LOAD, DRAIN, and in IDLE while start=1 (combinational); 0 otherwise.
REQ-023 Beat address: mem_addr = base + 4*cnt, computed modulo 2^N (wraps past 0xFFFFFFFC).
REQ-024 Lane mapping: beat i <-> vector bits [N*i+N-1 : N*i].
REQ-025 STORE: mem_we=1, mem_wd = lane cnt of captured store_data; cnt increments each cycle; after cnt=7, next state COMMIT.
REQ-026 LOAD: mem_we=0, issue address for beat cnt; the lane for cnt-1 is captured from mem_rd when cnt>0; after cnt=7, next state DRAIN.
REQ-027 DRAIN: capture lane 7 from mem_rd; no address issued (mem_addr=0); next state COMMIT.
REQ-028 COMMIT: done=1, stall=0; for loads vwe=1, vwa = captured wa3, vwd = assembled vector; for stores vwe=0; next state IDLE.
REQ-029 Latency from start cycle T: store, beats T+1..T+8, done at T+9; load, addresses T+1..T+8, done/vwe at T+10.
REQ-030 start outside IDLE (including in COMMIT) is ignored; no queuing; back-to-back requests are separated by at least one IDLE cycle.
REQ-031 mem_we, vwe, done are 0 in every state not listed as asserting them; mem_addr, mem_wd, vwa, vwd are 0 when not in use.
REQ-032 Captured operands stay unchanged during the operation regardless of input changes.

Reset
REQ-033 rst=1 forces IDLE, cnt=0, captured operands and lane buffer to 0, and all outputs to 0, asynchronously, including mid-operation; no further mem_we or vwe for the aborted request.
REQ-034 After rst deasserts, the first rising edge with start=1 begins a new request normally.

Structure
REQ-035 Shared package vec_seq_pkg holds the state enum, BEATS, and the lane-select width constant.
REQ-036 One sub-module, vector_lane_buffer (V-bit register with per-lane N-bit write enable and synchronous clear), holds the load assembly.

Verification
REQ-037 Store with base 0x100 and lanes 0..7 = 0x11111111*(i+1) -> mem_we for 8 cycles at 0x100..0x11C with the matching words, done at T+9, stall low at T+9.
REQ-038 Load with base 0x200, wa3=7, and memory word i = 0xA0000000+i -> vwe at T+10 with vwa=7 and vwd lane i = 0xA0000000+i; stall high T..T+9.
REQ-039 base_addr=0xFFFFFFF8 store -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, ..., 0x14.
REQ-040 base_addr=0x103 -> treated as 0x100.
REQ-041 rst asserted at load beat 4 -> all outputs 0 immediately, no vwe, and a subsequent load completes correctly.
REQ-042 start held high through COMMIT -> a second request starts only on the following IDLE cycle.
